// File: rtl/divclk_ctrl.sv
// Run-time clock divider controller: divisor register, period counter, glitch-free start/stop/update.
// Optional burst mode (fixed number of periods per en rising edge) is enabled by defining DIVCLK_CTRL_BURST_EN.
`timescale 1ns/1ps

module divclk_ctrl #(
  parameter int               DIV_W       = 28,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(50_000_000)
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             en,
`ifdef DIVCLK_CTRL_BURST_EN
  input  logic [15:0]      burst_len,
  output logic             burst_done,
`endif
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clock_out,
  output logic             tick,
  output logic             busy,
  output logic [DIV_W-1:0] cur_div
);

  localparam logic [1:0] STOP = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] PEND = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt, cur_div_nxt, pend_div, pend_div_nxt;
  logic             xfer, cfg_bad, load_ok, boundary, start, burst_last, keep_running;

  assign cfg_ready    = (state != PEND);
  assign busy         = (state != STOP);
  assign xfer         = cfg_valid && cfg_ready;
  assign cfg_bad      = (cfg_div < DIV_W'(2));
  assign load_ok      = xfer && !cfg_bad;
  assign boundary     = busy && (cnt == cur_div - DIV_W'(1));
  assign tick         = boundary;
  assign keep_running = en && !burst_last;

`ifdef DIVCLK_CTRL_BURST_EN
  logic        en_q;
  logic [15:0] blen, bcnt;

  // A burst only starts on a rising edge of en, so a finished burst stays stopped while en is held.
  assign start      = en && !en_q;
  assign burst_last = (blen != 16'd0) && (bcnt == blen - 16'd1);

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      en_q       <= 1'b0;
      blen       <= 16'd0;
      bcnt       <= 16'd0;
      burst_done <= 1'b0;
    end else begin
      en_q       <= en;
      burst_done <= 1'b0;
      if (state == STOP && start) begin
        blen <= burst_len;
        bcnt <= 16'd0;
      end else if (boundary) begin
        bcnt <= bcnt + 16'd1;
        if (burst_last) burst_done <= 1'b1;
      end
    end
  end
`else
  assign start      = en;
  assign burst_last = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no path leaves a value held (no latch).
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = boundary ? '0 : cnt + DIV_W'(1);
    cur_div_nxt  = cur_div;
    pend_div_nxt = pend_div;
    case (state)
      STOP: begin
        cnt_nxt = '0;
        if (load_ok) cur_div_nxt = cfg_div;
        if (start)   state_nxt   = RUN;
      end
      RUN: begin
        // Stopping wins over a same-cycle update; the new divisor is then loaded directly as in STOP.
        if (boundary && !keep_running) begin
          state_nxt = STOP;
          if (load_ok) cur_div_nxt = cfg_div;
        end else if (load_ok) begin
          pend_div_nxt = cfg_div;
          state_nxt    = PEND;
        end
      end
      PEND: begin
        if (boundary) begin
          cur_div_nxt = pend_div;
          state_nxt   = keep_running ? RUN : STOP;
        end
      end
      default: begin
        state_nxt = STOP;
        cnt_nxt   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state     <= STOP;
      cnt       <= '0;
      cur_div   <= DEFAULT_DIV;
      pend_div  <= '0;
      clock_out <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cur_div   <= cur_div_nxt;
      pend_div  <= pend_div_nxt;
      // Registered from the next-cycle count and divisor, so the pin equals (cnt >= cur_div>>1) each cycle.
      clock_out <= (state_nxt != STOP) && (cnt_nxt >= (cur_div_nxt >> 1));
      cfg_err   <= xfer && cfg_bad;
    end
  end

endmodule

// File: tb/tb_divclk_ctrl.sv
// Directed self-checking bench for divclk_ctrl with DEFAULT_DIV=4; burst scenario runs when DIVCLK_CTRL_BURST_EN is defined.
`timescale 1ns/1ps

module tb_divclk_ctrl;
  localparam int W = 28;

  logic         clock_in, reset, en, cfg_valid;
  logic [W-1:0] cfg_div, cur_div;
  logic         cfg_ready, cfg_err, clock_out, tick, busy;
`ifdef DIVCLK_CTRL_BURST_EN
  logic [15:0]  burst_len;
  logic         burst_done;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  divclk_ctrl #(.DIV_W(W), .DEFAULT_DIV(28'd4)) dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .en        (en),
`ifdef DIVCLK_CTRL_BURST_EN
    .burst_len (burst_len),
    .burst_done(burst_done),
`endif
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .clock_out (clock_out),
    .tick      (tick),
    .busy      (busy),
    .cur_div   (cur_div)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  // Advance one clock_in cycle; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
`ifdef DIVCLK_CTRL_BURST_EN
    burst_len = 16'd0;
`endif
    repeat (3) @(posedge clock_in);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (clock_out !== 1'b0) $display("FAIL reset_clock_out: got %b want 0", clock_out); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (cur_div !== 28'd4) $display("FAIL reset_cur_div: got %0d want 4", cur_div); else n_pass++;
    n_checks++; if (cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); else n_pass++;
    n_checks++; if (tick !== 1'b0 || cfg_err !== 1'b0) $display("FAIL reset_tick_err: got %b%b want 00", tick, cfg_err); else n_pass++;
    // Run to cnt=2, queue an update, then reset asynchronously mid-cycle.
    en = 1'b1;
    step(); step(); step();
    n_checks++; if (clock_out !== 1'b1) $display("FAIL reset_pre_clock_out: got %b want 1", clock_out); else n_pass++;
    cfg_valid = 1'b1; cfg_div = 28'd9;
    step();
    cfg_valid = 1'b0;
    n_checks++; if (cfg_ready !== 1'b0) $display("FAIL reset_pre_pend: got %b want 0", cfg_ready); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (clock_out !== 1'b0 || busy !== 1'b0) $display("FAIL reset_async: got co=%b busy=%b want 0 0", clock_out, busy); else n_pass++;
    n_checks++; if (cfg_ready !== 1'b1 || cur_div !== 28'd4) $display("FAIL reset_async_cfg: got rdy=%b div=%0d want 1 4", cfg_ready, cur_div); else n_pass++;
    en = 1'b0;
    step();
    reset = 1'b0;
    step(); step(); step(); step(); step();
    n_checks++; if (cur_div !== 28'd4 || busy !== 1'b0) $display("FAIL reset_pend_discard: got div=%0d busy=%b want 4 0", cur_div, busy); else n_pass++;
  endtask

  task automatic test_basic_run();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++; if (clock_out !== ((i % 4) >= 2)) $display("FAIL run4_clock_out[%0d]: got %b want %b", i, clock_out, (i % 4) >= 2); else n_pass++;
      n_checks++; if (tick !== ((i % 4) == 3) || busy !== 1'b1) $display("FAIL run4_tick[%0d]: got tick=%b busy=%b want %b 1", i, tick, busy, (i % 4) == 3); else n_pass++;
    end
    do_reset();
    cfg_valid = 1'b1; cfg_div = 28'd5;
    step();
    cfg_valid = 1'b0;
    n_checks++; if (cur_div !== 28'd5 || busy !== 1'b0) $display("FAIL stop_load: got div=%0d busy=%b want 5 0", cur_div, busy); else n_pass++;
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++; if (clock_out !== ((i % 5) >= 2)) $display("FAIL run5_clock_out[%0d]: got %b want %b", i, clock_out, (i % 5) >= 2); else n_pass++;
      n_checks++; if (tick !== ((i % 5) == 4)) $display("FAIL run5_tick[%0d]: got %b want %b", i, tick, (i % 5) == 4); else n_pass++;
    end
  endtask

  task automatic test_glitch_free_update();
    do_reset();
    en = 1'b1;
    step(); step();
    n_checks++; if (cfg_ready !== 1'b1) $display("FAIL upd_ready_before: got %b want 1", cfg_ready); else n_pass++;
    cfg_valid = 1'b1; cfg_div = 28'd6;
    step();
    cfg_valid = 1'b0;
    n_checks++; if (cfg_ready !== 1'b0 || cur_div !== 28'd4 || clock_out !== 1'b1) $display("FAIL upd_pend_cnt2: got rdy=%b div=%0d co=%b want 0 4 1", cfg_ready, cur_div, clock_out); else n_pass++;
    step();
    n_checks++; if (tick !== 1'b1 || cfg_ready !== 1'b0) $display("FAIL upd_pend_cnt3: got tick=%b rdy=%b want 1 0", tick, cfg_ready); else n_pass++;
    step();
    n_checks++; if (cur_div !== 28'd6 || cfg_ready !== 1'b1) $display("FAIL upd_switch: got div=%0d rdy=%b want 6 1", cur_div, cfg_ready); else n_pass++;
    for (int i = 0; i < 12; i++) begin
      n_checks++; if (clock_out !== ((i % 6) >= 3) || tick !== ((i % 6) == 5)) $display("FAIL run6[%0d]: got co=%b tick=%b want %b %b", i, clock_out, tick, (i % 6) >= 3, (i % 6) == 5); else n_pass++;
      step();
    end
  endtask

  task automatic test_boundary_collision();
    do_reset();
    en = 1'b1;
    repeat (4) step();
    n_checks++; if (tick !== 1'b1) $display("FAIL coll_tick: got %b want 1", tick); else n_pass++;
    cfg_valid = 1'b1; cfg_div = 28'd8;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (cur_div !== 28'd4 || cfg_ready !== 1'b0 || tick !== (i == 3) || clock_out !== (i >= 2)) $display("FAIL coll_old[%0d]: got div=%0d rdy=%b tick=%b co=%b", i, cur_div, cfg_ready, tick, clock_out); else n_pass++;
      step();
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (cur_div !== 28'd8 || clock_out !== ((i % 8) >= 4) || tick !== ((i % 8) == 7)) $display("FAIL coll_new[%0d]: got div=%0d co=%b tick=%b", i, cur_div, clock_out, tick); else n_pass++;
      step();
    end
    cfg_valid = 1'b1; cfg_div = 28'd1;
    step();
    cfg_valid = 1'b0;
    n_checks++; if (cfg_err !== 1'b1) $display("FAIL rej_err: got %b want 1", cfg_err); else n_pass++;
    n_checks++; if (cur_div !== 28'd8 || cfg_ready !== 1'b1 || busy !== 1'b1) $display("FAIL rej_state: got div=%0d rdy=%b busy=%b want 8 1 1", cur_div, cfg_ready, busy); else n_pass++;
    step();
    n_checks++; if (cfg_err !== 1'b0 || cfg_ready !== 1'b1 || clock_out !== 1'b0) $display("FAIL rej_after: got err=%b rdy=%b co=%b want 0 1 0", cfg_err, cfg_ready, clock_out); else n_pass++;
  endtask

  task automatic test_stop();
    do_reset();
    cfg_valid = 1'b1; cfg_div = 28'd6;
    step();
    cfg_valid = 1'b0;
    en = 1'b1;
    step();
    en = 1'b0;
    for (int i = 1; i < 6; i++) begin
      step();
      n_checks++; if (busy !== 1'b1 || clock_out !== (i >= 3)) $display("FAIL stop_drain[%0d]: got busy=%b co=%b want 1 %b", i, busy, clock_out, i >= 3); else n_pass++;
    end
    step();
    n_checks++; if (busy !== 1'b0 || clock_out !== 1'b0 || tick !== 1'b0) $display("FAIL stop_final: got busy=%b co=%b tick=%b want 0 0 0", busy, clock_out, tick); else n_pass++;
    step(); step();
    n_checks++; if (busy !== 1'b0 || cur_div !== 28'd6) $display("FAIL stop_hold: got busy=%b div=%0d want 0 6", busy, cur_div); else n_pass++;
  endtask

`ifdef DIVCLK_CTRL_BURST_EN
  task automatic test_burst();
    int ticks, dones;
    do_reset();
    burst_len = 16'd3;
    en = 1'b1;
    ticks = 0; dones = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick) ticks++;
      if (burst_done) dones++;
    end
    n_checks++; if (ticks != 3 || dones != 1) $display("FAIL burst1: got ticks=%0d done=%0d want 3 1", ticks, dones); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL burst1_stop: got busy=%b want 0", busy); else n_pass++;
    en = 1'b0;
    step();
    en = 1'b1;
    ticks = 0; dones = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick) ticks++;
      if (burst_done) dones++;
    end
    n_checks++; if (ticks != 3 || dones != 1 || busy !== 1'b0) $display("FAIL burst2: got ticks=%0d done=%0d busy=%b want 3 1 0", ticks, dones, busy); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_run();
    test_glitch_free_update();
    test_boundary_collision();
    test_stop();
`ifdef DIVCLK_CTRL_BURST_EN
    test_burst();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
